// File: rtl/hilo_pkg.sv
// Shared opcodes and FSM encoding for the Hi/Lo multiply sequencer; the ALU
// control decoder uses the same opcode constants.
package hilo_pkg;

  localparam int ALUCTL_W = 5;

  localparam logic [ALUCTL_W-1:0] ALU_MULT  = 5'b00101;
  localparam logic [ALUCTL_W-1:0] ALU_MULTU = 5'b01100;
  localparam logic [ALUCTL_W-1:0] ALU_MADD  = 5'b11010;
  localparam logic [ALUCTL_W-1:0] ALU_MSUB  = 5'b01101;
  localparam logic [ALUCTL_W-1:0] ALU_MTHI  = 5'b10001;
  localparam logic [ALUCTL_W-1:0] ALU_MTLO  = 5'b10011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic logic is_mul_op(input logic [ALUCTL_W-1:0] op);
    case (op)
      ALU_MULT, ALU_MULTU, ALU_MADD, ALU_MSUB: is_mul_op = 1'b1;
      default:                                 is_mul_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_op(input logic [ALUCTL_W-1:0] op);
    case (op)
      ALU_MULT, ALU_MADD, ALU_MSUB: is_signed_op = 1'b1;
      default:                      is_signed_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_move_op(input logic [ALUCTL_W-1:0] op);
    case (op)
      ALU_MTHI, ALU_MTLO: is_move_op = 1'b1;
      default:            is_move_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hilo_sequencer_if.sv
// Pipeline-side request/result bundle of the Hi/Lo sequencer.
interface hilo_sequencer_if
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic                Start;
  logic [ALUCTL_W-1:0] ALUCtl;
  logic [WIDTH-1:0]    A;
  logic [WIDTH-1:0]    B;
  logic                Busy;
  logic                Done;
  logic [WIDTH-1:0]    Hi;
  logic [WIDTH-1:0]    Lo;

  modport master (output Start, ALUCtl, A, B, input Busy, Done, Hi, Lo);
  modport slave  (input Start, ALUCtl, A, B, output Busy, Done, Hi, Lo);
endinterface

// File: rtl/hilo_sequencer_mul_iter.sv
// mul_iter: unsigned radix-2 shift-add multiplier, one iteration per step;
// last flags the cycle in which the final (WIDTH-th) iteration is applied.
module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [CW-1:0]      count_r;

  // Shift-add datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (load) begin
      mcand_r  <= {{WIDTH{1'b0}}, mcand};
      mplier_r <= mplier;
      acc_r    <= {(2*WIDTH){1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (step) begin
      if (mplier_r[0]) begin
        acc_r <= acc_r + mcand_r;
      end
      mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      count_r  <= count_r + CNT_ONE;
    end
  end

  assign product = acc_r;
  assign last    = (count_r == CNT_LAST);
endmodule

// File: rtl/hilo_sequencer.sv
// Hi/Lo multiply/accumulate sequencer. Define HILO_FAST_MUL_EN to replace the
// WIDTH-cycle shift-add loop with a single-cycle product.
module hilo_sequencer
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic            Clk,
  input  logic            Reset,
  hilo_sequencer_if.slave bus
);
  state_e                state_r, state_next_s;
  logic [ALUCTL_W-1:0]   op_r;
  logic                  neg_r;
  logic [WIDTH-1:0]      hi_r, lo_r;
  logic                  busy_r, done_r;
  logic                  start_mul_s, start_mov_s, signed_s, neg_s;
  logic [WIDTH-1:0]      mag_a_s, mag_b_s;
  logic                  load_s, step_s, last_s;
  logic [2*WIDTH-1:0]    prod_s, prod_fix_s, hilo_next_s;

  // Request decode and operand magnitudes (-2^(WIDTH-1) maps to 2^(WIDTH-1))
  always_comb begin
    start_mul_s = bus.Start & is_mul_op(bus.ALUCtl);
    start_mov_s = bus.Start & is_move_op(bus.ALUCtl);
    signed_s    = is_signed_op(bus.ALUCtl);
    mag_a_s     = (signed_s && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    mag_b_s     = (signed_s && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    neg_s       = signed_s & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
  end

`ifdef HILO_FAST_MUL_EN
  logic [WIDTH-1:0] mag_a_r, mag_b_r;

  // Operand magnitudes held for the single-cycle product
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mag_a_r <= {WIDTH{1'b0}};
      mag_b_r <= {WIDTH{1'b0}};
    end else if (state_r == ST_IDLE && start_mul_s) begin
      mag_a_r <= mag_a_s;
      mag_b_r <= mag_b_s;
    end
  end

  assign prod_s = {{WIDTH{1'b0}}, mag_a_r} * {{WIDTH{1'b0}}, mag_b_r};
  assign last_s = 1'b1;
`else
  mul_iter #(.WIDTH(WIDTH)) u_mul_iter (
    .clk     (Clk),
    .reset   (Reset),
    .load    (load_s),
    .step    (step_s),
    .mcand   (mag_a_s),
    .mplier  (mag_b_s),
    .product (prod_s),
    .last    (last_s)
  );
`endif

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_mul_s) begin
          load_s = 1'b1;
`ifdef HILO_FAST_MUL_EN
          state_next_s = ST_FIX;
`else
          state_next_s = ST_MUL;
`endif
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        step_s = 1'b1;
        if (last_s) begin
          state_next_s = ST_FIX;
        end else begin
          state_next_s = ST_MUL;
        end
      end
      ST_FIX:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Sign fix-up and accumulate into the current Hi:Lo
  always_comb begin
    prod_fix_s = neg_r ? -prod_s : prod_s;
    case (op_r)
      ALU_MADD: hilo_next_s = {hi_r, lo_r} + prod_fix_s;
      ALU_MSUB: hilo_next_s = {hi_r, lo_r} - prod_fix_s;
      default:  hilo_next_s = prod_fix_s;
    endcase
  end

  // Hi/Lo, captured request, and registered handshake outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      op_r   <= {ALUCTL_W{1'b0}};
      neg_r  <= 1'b0;
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s != ST_IDLE);
      done_r <= (state_r == ST_FIX) || (state_r == ST_IDLE && start_mov_s);
      if (state_r == ST_IDLE && start_mul_s) begin
        op_r  <= bus.ALUCtl;
        neg_r <= neg_s;
      end
      if (state_r == ST_FIX) begin
        {hi_r, lo_r} <= hilo_next_s;
      end else if (state_r == ST_IDLE && start_mov_s) begin
        if (bus.ALUCtl == ALU_MTHI) begin
          hi_r <= bus.A;
        end else begin
          lo_r <= bus.A;
        end
      end
    end
  end

  assign bus.Busy = busy_r;
  assign bus.Done = done_r;
  assign bus.Hi   = hi_r;
  assign bus.Lo   = lo_r;
endmodule

// File: doc/hilo_sequencer.md
HILO_SEQUENCER -- requirements
Module: hilo_sequencer

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width; Hi and Lo are each WIDTH bits; product is 2*WIDTH bits.
REQ-002 SHALL have port: Clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: Reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: Start  in  1  request qualifier, sampled each cycle.
REQ-005 SHALL have port: ALUCtl  in  5  operation code: mult 00101, multu 01100, madd 11010, msub 01101, mthi 10001, mtlo 10011.
REQ-006 SHALL have port: A  in  WIDTH  rs operand.
REQ-007 SHALL have port: B  in  WIDTH  rt operand.
REQ-008 SHALL have port: Busy  out  1  stall request to the pipeline; high while state is not IDLE.
REQ-009 SHALL have port: Done  out  1  one-cycle pulse; Hi/Lo already hold the new result in that cycle.
REQ-010 SHALL have port: Hi  out  WIDTH  registered Hi.
REQ-011 SHALL have port: Lo  out  WIDTH  registered Lo.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, FIX.
REQ-013 In IDLE with Start=1 and a multiply code (cycle 0), SHALL latch operand magnitudes, result-sign flag and opcode, and go to MUL with iteration counter 0.
REQ-014 MUL SHALL perform one shift-add iteration per cycle and go to FIX after exactly WIDTH iterations (cycles 1..WIDTH).
REQ-015 FIX (cycle WIDTH+1) SHALL negate the product when the result sign is negative, then write Hi:Lo as follows: product for mult/multu, Hi:Lo+product for madd, Hi:Lo-product for msub; then return to IDLE.
REQ-016 Done SHALL be 1 in cycle WIDTH+2 only; Busy SHALL be 1 in cycles 1..WIDTH+1 only.
REQ-017 mult, madd and msub SHALL be signed (two's complement); multu SHALL be unsigned; madd/msub arithmetic SHALL wrap modulo 2^(2*WIDTH).
REQ-018 Magnitude of the most-negative operand (-2^(WIDTH-1)) SHALL be represented correctly as unsigned.
REQ-019 mthi/mtlo in IDLE with Start=1 SHALL write A to Hi/Lo at the end of cycle 0 and pulse Done in cycle 1; Busy SHALL NOT assert.
REQ-020 Start with any other ALUCtl code SHALL be ignored: no state change and no Done.
REQ-021 Start while Busy=1 SHALL be ignored; the pipeline holds the instruction until Busy falls.
REQ-022 A new Start accepted in a Done cycle SHALL be processed normally (back-to-back, no bubble).
REQ-023 Hi/Lo SHALL change only at the FIX write or the mthi/mtlo write.

Reset
REQ-024 Reset=1 SHALL force IDLE, Hi=0, Lo=0, Busy=0, Done=0 and counter 0 at the next edge.
REQ-025 Reset during MUL or FIX SHALL discard the operation; no Done pulse follows.
REQ-026 Reset SHALL take priority over a simultaneous Start.

Configuration
REQ-027 Macro HILO_FAST_MUL_EN defined: the MUL state SHALL be bypassed; the product SHALL be computed in one cycle and written in FIX (cycle 1), with Busy in cycle 1 only and Done in cycle 2.
REQ-028 Macro HILO_FAST_MUL_EN absent: the iterative WIDTH-cycle path per REQ-014 SHALL be used.

Structure
REQ-029 Shared package hilo_pkg SHALL hold the ALUCtl opcode constants (shared with the ALU control decoder) and the FSM state encoding.
REQ-030 The shift-add datapath (multiplicand, multiplier, partial product, counter) SHALL be sub-module mul_iter; the FSM, sign handling, accumulation and Hi/Lo SHALL remain in hilo_sequencer.

Verification
REQ-031 mult A=-3 (FFFFFFFD), B=7 -> Done in cycle 34; Hi=FFFFFFFF, Lo=FFFFFFEB.
REQ-032 multu A=FFFFFFFF, B=FFFFFFFF -> Hi=FFFFFFFE, Lo=00000001.
REQ-033 mthi A=00000001, then mtlo A=00000000, then madd A=2, B=3 -> Hi=00000001, Lo=00000006; then msub A=2, B=4 -> Hi=00000000, Lo=FFFFFFFE.
REQ-034 mult A=80000000, B=80000000 -> Hi=40000000, Lo=00000000; a second Start at cycle 5 is ignored (exactly one Done).
REQ-035 Reset asserted in cycle 10 of a mult -> Busy=0, Hi=Lo=0 next cycle; no Done within 40 cycles.
REQ-036 Back-to-back: a second mult Start in the Done cycle -> a second Done exactly 34 cycles later; with HILO_FAST_MUL_EN, the first Done falls in cycle 2.
